// File: rtl/led_frame_scheduler.sv
// Double-buffered 8x8 red/green LED frame controller.
// Draws go to the hidden back buffer; swaps land on frame boundaries.
module led_frame_scheduler #(
  parameter int unsigned HOLD_FRAMES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_sync,
  input  logic            wr_req,
  input  logic [2:0]      wr_row,
  input  logic [2:0]      wr_col,
  input  logic [1:0]      wr_color,
  output logic            wr_ack,
  input  logic            clr_req,
  input  logic            swap_req,
  output logic            swap_done,
  output logic            busy,
  output logic [7:0][7:0] red_array,
  output logic [7:0][7:0] green_array
);

  localparam logic [3:0] HOLD = 4'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WAIT_SWAP,
    COPY
  } state_t;

  state_t               state;
  logic [2:0]           row_cnt;
  logic [3:0]           frames_shown;
  logic                 front_sel;
  logic                 back_sel;
  logic                 swap_ok;
  logic [1:0][7:0][7:0] red_buf;
  logic [1:0][7:0][7:0] grn_buf;

  assign back_sel    = ~front_sel;
  assign red_array   = red_buf[front_sel];
  assign green_array = grn_buf[front_sel];

  // 5-bit compare so frames_shown + 1 cannot wrap
  assign swap_ok = frame_sync &&
    (({1'b0, frames_shown} + 5'd1) >= {1'b0, HOLD});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      row_cnt      <= '0;
      frames_shown <= '0;
      front_sel    <= 1'b0;
      red_buf      <= '0;
      grn_buf      <= '0;
      wr_ack       <= 1'b0;
      swap_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      wr_ack    <= 1'b0;
      swap_done <= 1'b0;
      if (frame_sync && frames_shown < HOLD)
        frames_shown <= frames_shown + 4'd1;
      unique case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            row_cnt <= '0;
            busy    <= 1'b1;
          end else if (swap_req) begin
            state <= WAIT_SWAP;
            busy  <= 1'b1;
          end else if (wr_req && !wr_ack) begin
            red_buf[back_sel][wr_row][wr_col] <= wr_color[0];
            grn_buf[back_sel][wr_row][wr_col] <= wr_color[1];
            wr_ack <= 1'b1;
          end
        end
        CLEAR: begin
          red_buf[back_sel][row_cnt] <= '0;
          grn_buf[back_sel][row_cnt] <= '0;
          row_cnt <= row_cnt + 3'd1;
          if (row_cnt == 3'd7) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WAIT_SWAP: begin
          if (swap_ok) begin
            front_sel    <= ~front_sel;
            frames_shown <= '0;
            row_cnt      <= '0;
            state        <= COPY;
          end
        end
        COPY: begin
          // front_sel already points at the new front here
          red_buf[back_sel][row_cnt] <= red_buf[front_sel][row_cnt];
          grn_buf[back_sel][row_cnt] <= grn_buf[front_sel][row_cnt];
          row_cnt <= row_cnt + 3'd1;
          if (row_cnt == 3'd7) begin
            state     <= IDLE;
            busy      <= 1'b0;
            swap_done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler.
// Two instances: HOLD_FRAMES=1 and HOLD_FRAMES=3 sharing stimulus.
module tb_led_frame_scheduler;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            frame_sync = 1'b0;
  logic            wr_req = 1'b0;
  logic [2:0]      wr_row = '0;
  logic [2:0]      wr_col = '0;
  logic [1:0]      wr_color = '0;
  logic            clr_req = 1'b0;
  logic            swap_req = 1'b0;

  logic            ack1, done1, busy1;
  logic [7:0][7:0] red1, grn1;
  logic            ack3, done3, busy3;
  logic [7:0][7:0] red3, grn3;

  logic            sel3 = 1'b0;
  logic            obs_ack, obs_done, obs_busy;
  logic [7:0][7:0] obs_red, obs_grn;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_red [2];
  logic [63:0] m_grn [2];
  logic        m_front;

  always #5 clk = ~clk;

  led_frame_scheduler #(.HOLD_FRAMES(1)) dut (
    .clk(clk), .reset(reset), .frame_sync(frame_sync),
    .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col),
    .wr_color(wr_color), .wr_ack(ack1), .clr_req(clr_req),
    .swap_req(swap_req), .swap_done(done1), .busy(busy1),
    .red_array(red1), .green_array(grn1)
  );

  led_frame_scheduler #(.HOLD_FRAMES(3)) dut3 (
    .clk(clk), .reset(reset), .frame_sync(frame_sync),
    .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col),
    .wr_color(wr_color), .wr_ack(ack3), .clr_req(clr_req),
    .swap_req(swap_req), .swap_done(done3), .busy(busy3),
    .red_array(red3), .green_array(grn3)
  );

  always_comb begin
    obs_ack  = sel3 ? ack3  : ack1;
    obs_done = sel3 ? done3 : done1;
    obs_busy = sel3 ? busy3 : busy1;
    obs_red  = sel3 ? red3  : red1;
    obs_grn  = sel3 ? grn3  : grn1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_red[0] = '0; m_red[1] = '0;
    m_grn[0] = '0; m_grn[1] = '0;
    m_front = 1'b0;
  endtask

  task automatic m_write(input logic [2:0] r, input logic [2:0] c,
                         input logic [1:0] col);
    m_red[!m_front][{r, c}] = col[0];
    m_grn[!m_front][{r, c}] = col[1];
  endtask

  task automatic m_swap();
    m_front = !m_front;
    m_red[!m_front] = m_red[m_front];
    m_grn[!m_front] = m_grn[m_front];
  endtask

  task automatic m_clear();
    m_red[!m_front] = '0;
    m_grn[!m_front] = '0;
  endtask

  task automatic chk_front(input string nm);
    chk({nm, " red"}, obs_red, m_red[m_front]);
    chk({nm, " green"}, obs_grn, m_grn[m_front]);
  endtask

  task automatic do_write(input logic [2:0] r, input logic [2:0] c,
                          input logic [1:0] col);
    wr_row = r; wr_col = c; wr_color = col; wr_req = 1'b1;
    @(negedge clk);
    chk("wr_ack rise", obs_ack, 1);
    wr_req = 1'b0;
    m_write(r, c, col);
    @(negedge clk);
    chk("wr_ack single", obs_ack, 0);
  endtask

  // nfs frame_sync pulses, three cycles apart, then wait for swap_done
  task automatic do_swap(input int nfs);
    bit seen;
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    chk("busy after swap_req", obs_busy, 1);
    for (int f = 0; f < nfs; f++) begin
      repeat (2) @(negedge clk);
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
    end
    m_swap();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (obs_done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("swap_done seen", seen, 1);
    @(negedge clk);
    chk("busy after swap", obs_busy, 0);
    chk_front("after swap");
  endtask

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] color;
    logic       exp_r;
    logic       exp_g;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int first_done, pulses, cnt;
    bit seen;

    vecs[0] = '{3'd3, 3'd5, 2'b11, 1'b1, 1'b1};
    vecs[1] = '{3'd0, 3'd0, 2'b01, 1'b1, 1'b0};
    vecs[2] = '{3'd7, 3'd7, 2'b10, 1'b0, 1'b1};
    vecs[3] = '{3'd1, 3'd4, 2'b11, 1'b0, 1'b0};
    vecs[4] = '{3'd1, 3'd4, 2'b00, 1'b0, 1'b0};
    vecs[5] = '{3'd6, 3'd2, 2'b01, 1'b1, 1'b0};

    m_reset();
    repeat (2) @(negedge clk);
    chk("reset red", obs_red, 0);
    chk("reset green", obs_grn, 0);
    chk("reset busy", obs_busy, 0);
    chk("reset wr_ack", obs_ack, 0);
    chk("reset swap_done", obs_done, 0);
    reset = 1'b0;
    @(negedge clk);

    // write with no swap leaves the display dark
    do_write(3'd2, 3'd2, 2'b01);
    chk("no-swap red", obs_red, 0);
    chk("no-swap green", obs_grn, 0);

    // write, swap, frame_sync 20 cycles later, exact swap_done timing
    do_write(3'd3, 3'd5, 2'b11);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    chk("busy rises", obs_busy, 1);
    repeat (19) @(negedge clk);
    chk("pre-swap red", obs_red, 0);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    m_swap();
    chk("swap edge red35", obs_red[3][5], 1);
    chk("swap edge green35", obs_grn[3][5], 1);
    chk_front("swap edge");
    first_done = -1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (obs_done) begin
        pulses++;
        if (first_done < 0) first_done = i;
      end
      if (i == 7) chk("busy before done", obs_busy, 1);
      if (i == 8) chk("busy falls with done", obs_busy, 0);
    end
    chk("swap_done cycle", 64'(first_done), 8);
    chk("swap_done pulses", 64'(pulses), 1);
    do_swap(1);
    chk("readback red35", obs_red[3][5], 1);
    chk("readback green35", obs_grn[3][5], 1);

    // table of writes, then one swap and per-pixel checks
    foreach (vecs[i]) do_write(vecs[i].row, vecs[i].col, vecs[i].color);
    do_swap(1);
    foreach (vecs[i]) begin
      chk("vec red", obs_red[vecs[i].row][vecs[i].col], vecs[i].exp_r);
      chk("vec green", obs_grn[vecs[i].row][vecs[i].col], vecs[i].exp_g);
    end

    // fill back buffer, clear it, swap: display is dark
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        do_write(3'(r), 3'(c), 2'b10);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (obs_busy) cnt++;
      @(negedge clk);
    end
    chk("clear busy cycles", 64'(cnt), 8);
    m_clear();
    do_swap(1);
    chk("cleared front red", obs_red, 0);
    chk("cleared front green", obs_grn, 0);

    // clr + swap + wr together: clear wins, swap dropped, write waits
    clr_req = 1'b1; swap_req = 1'b1;
    wr_req = 1'b1; wr_row = 3'd6; wr_col = 3'd1; wr_color = 2'b11;
    cnt = -1;
    for (int k = 1; k <= 20 && cnt < 0; k++) begin
      @(negedge clk);
      clr_req = 1'b0; swap_req = 1'b0;
      if (obs_ack) cnt = k;
    end
    wr_req = 1'b0;
    chk("pending write ack cycle", 64'(cnt), 10);
    m_clear();
    m_write(3'd6, 3'd1, 2'b11);
    @(negedge clk);
    chk("idle after pending write", obs_busy, 0);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    repeat (3) @(negedge clk);
    chk("swap dropped busy", obs_busy, 0);
    chk_front("swap dropped");
    do_swap(1);
    chk("pending pixel shown", obs_red[6][1], 1);

    // async reset in COPY row 4
    do_write(3'd0, 3'd1, 2'b01);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    repeat (2) @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    m_reset();
    chk("async reset red", obs_red, 0);
    chk("async reset green", obs_grn, 0);
    chk("async reset busy", obs_busy, 0);
    chk("async reset done", obs_done, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (obs_done) seen = 1'b1;
    end
    chk("no done after reset", seen, 0);
    do_write(3'd4, 3'd4, 2'b10);
    do_swap(1);
    chk("post-reset pixel", obs_grn[4][4], 1);

    // HOLD_FRAMES=3: swap right after a swap needs 3 frame_syncs
    sel3 = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    do_write(3'd0, 3'd7, 2'b11);
    do_swap(3);
    do_write(3'd5, 3'd5, 2'b01);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      repeat (2) @(negedge clk);
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
      if (f == 3) m_swap();
      chk("hold3 red55", obs_red[5][5], (f == 3) ? 1 : 0);
      chk_front("hold3 front");
    end
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (obs_done) seen = 1'b1;
    end
    chk("hold3 swap_done", seen, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Double-buffered frame controller for the 8x8 red/green LED matrix. Game logic draws pixels and clears into a hidden back buffer through a request/acknowledge port. The front buffer drives the row-scanning matrix driver's red/green array inputs. Swaps are deferred to a frame boundary so the display never shows a half-drawn frame, and the new back buffer is refreshed from the new front, so drawing is incremental.

## Interface
- HOLD_FRAMES, 1: minimum completed frames a front buffer is displayed before a swap may occur; legal range 1..15.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- frame_sync  input  1  one-cycle pulse marking the end of a full 8-row scan.
- wr_req  input  1  pixel write request; held until wr_ack.
- wr_row  input  3  write row index, 0..7.
- wr_col  input  3  write column index, 0..7.
- wr_color  input  2  bit0 = red, bit1 = green; 2'b00 erases the pixel.
- wr_ack  output  1  one-cycle pulse; the write is committed to the back buffer.
- clr_req  input  1  strobe: zero the whole back buffer.
- swap_req  input  1  strobe: present the back buffer at the next eligible frame boundary.
- swap_done  output  1  one-cycle pulse when the swap and refresh copy have completed.
- busy  output  1  high in any state other than IDLE.
- red_array  output  [7:0][7:0]  front-buffer red plane, indexed [row][col].
- green_array  output  [7:0][7:0]  front-buffer green plane, indexed [row][col].

## Operation
- Storage:
  - Two buffers, buf0 and buf1, each holding a red and a green 8x8 plane.
  - Register front_sel selects the displayed buffer. The back buffer is the other one.
  - red_array and green_array are a combinational mux of the front buffer by front_sel.
- States:
  - IDLE.
  - CLEAR: 8 cycles, 3-bit row counter.
  - WAIT_SWAP.
  - COPY: 8 cycles, 3-bit row counter.
- IDLE, acceptance priority within a cycle: clr_req > swap_req > wr_req.
  - clr_req goes to CLEAR with row counter at 0.
  - swap_req goes to WAIT_SWAP.
  - wr_req with wr_ack low writes back[wr_row][wr_col] for both planes from wr_color. wr_ack goes high the next cycle and the state stays IDLE.
- CLEAR: zeroes back-buffer row = counter in both planes each cycle. After row 7 it returns to IDLE.
- WAIT_SWAP: on a frame_sync cycle where frames_shown + 1 >= HOLD_FRAMES, it does three things at that edge:
  - toggles front_sel;
  - clears frames_shown to 0;
  - enters COPY with the counter at 0.
- COPY: copies row = counter of the new front into the new back each cycle, both planes. After row 7 it pulses swap_done and returns to IDLE.
- frames_shown: 4-bit counter.
  - Increments on every frame_sync in all states, saturating at HOLD_FRAMES.
  - Cleared on swap.
- Strobes clr_req and swap_req are honoured only in IDLE. When busy=1 they are dropped, so requesters must check busy first.
- wr_req is ignored while busy. A pending write stays pending and is accepted on return to IDLE.
- Writes never touch the front buffer. The front buffer changes only at the swap edge.
- Reset, asynchronous, at any time including mid-CLEAR or mid-COPY:
  - state goes to IDLE;
  - both buffers and front_sel go to 0;
  - frames_shown, counters, wr_ack, swap_done and busy go to 0.

## Timing
- Write latency: wr_req sampled high at edge N, with IDLE and wr_ack low. Data is in the back buffer after edge N and wr_ack is high for cycle N..N+1.
  - A wr_req still high during the ack cycle is not re-sampled.
  - Maximum write rate is 1 per 2 cycles.
- Clear: busy is high for exactly 8 cycles after the accepting edge.
- Swap:
  - busy rises the cycle after acceptance.
  - The front buffer changes at the qualifying frame_sync edge.
  - swap_done pulses 8 cycles after that edge, and busy falls with it.
- A frame_sync coinciding with acceptance of swap_req is counted in frames_shown but does not itself trigger the swap. The earliest swap is at the next frame_sync.
- Outputs red_array and green_array reset to all zeros.

## Test plan
- Reset, then write (row 3, col 5, color 2'b11), swap_req, HOLD_FRAMES=1, frame_sync pulsed 20 cycles later:
  - red_array[3][5]=1 and green_array[3][5]=1 from the swap edge;
  - swap_done exactly 8 cycles later;
  - a back-buffer readback via a second swap shows the same pixel, proving the copy.
- Write (2,2,2'b01) with no swap -> red_array and green_array stay all zeros; wr_ack is a single cycle one cycle after acceptance.
- HOLD_FRAMES=3, swap_req right after a swap -> no front change on the 1st or 2nd frame_sync; the swap occurs on the 3rd.
- Fill the back buffer, then clr_req, then swap -> busy high for 8 cycles during the clear; the displayed frame is all zeros.
- clr_req, swap_req and wr_req in the same IDLE cycle -> CLEAR entered, swap dropped, write acked 9 cycles later.
- Assert reset during COPY row 4 -> all outputs 0 immediately (asynchronous); no swap_done pulse; next write and swap behave normally.
